// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge-to-pulse generator.
//   edge_mode_t     : per-channel edge selection (off / rise / fall / both)
//   DEF_SYNC_STAGES : default synchroniser depth
//   edge_qualifies  : decides whether an accepted edge should emit a pulse
package edge_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   localparam int unsigned DEF_SYNC_STAGES = 2;

   // True when an accepted edge of the given direction matches the mode
   function automatic logic edge_qualifies(input edge_mode_t mode,
                                           input logic       rise,
                                           input logic       fall);
      logic hit;
      hit = 1'b0;
      case (mode)
         EDGE_RISE: hit = rise;
         EDGE_FALL: hit = fall;
         EDGE_BOTH: hit = rise | fall;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/edge_chan.sv
// Single-bit edge channel: synchroniser, persistence filter, level register
// and mode-qualified one-clock pulse.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   en       : pulse enable (filter keeps tracking while low)
//   d        : raw asynchronous input
//   mode     : edge selection for this channel
//   q        : registered one-clock pulse, high in the cycle level changes
//   level    : filtered, synchronised level
//   pulse_c  : combinational next value of q (feeds the top-level OR)
module edge_chan
   import edge_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned FILTER_CYCLES = 1,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       d,
   input  edge_mode_t mode,
   output logic       q,
   output logic       level,
   output logic       pulse_c
);

   localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   q_q;
   logic                   s;
   logic                   accept_c;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift: d enters at stage 0
   always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Persistence filter: a new level must be seen FILTER_CYCLES times in a row
   always_comb begin
      cnt_d    = cnt_q;
      level_d  = level_q;
      accept_c = 1'b0;
      if (s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
         level_d  = s;
         cnt_d    = '0;
         accept_c = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Direction follows the newly accepted level
   assign pulse_c = en & edge_qualifies(mode, accept_c & s, accept_c & ~s);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
         cnt_q   <= '0;
         level_q <= INIT_LEVEL;
         q_q     <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         q_q     <= pulse_c;
      end
   end

   assign q     = q_q;
   assign level = level_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: one edge_chan per input bit plus a
// registered OR of all pulses.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   en       : global pulse enable
//   d        : raw asynchronous inputs, one per channel
//   mode     : per-channel edge_mode_t, channel i at [2i+1:2i]
//   q        : one-clock edge pulses
//   level    : filtered, synchronised level per channel
//   any_q    : OR of q, aligned with q
module edge_pulse_gen
   import edge_pkg::*;
#(
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned FILTER_CYCLES = 1,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [CHANNELS-1:0]   d,
   input  logic [2*CHANNELS-1:0] mode,
   output logic [CHANNELS-1:0]   q,
   output logic [CHANNELS-1:0]   level,
   output logic                  any_q
);

   logic [CHANNELS-1:0] pulse_c;
   logic                any_q_q, any_q_d;

   for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
      edge_chan #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES),
         .INIT_LEVEL    (INIT_LEVEL)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .d       (d[i]),
         .mode    (edge_mode_t'(mode[2*i +: 2])),
         .q       (q[i]),
         .level   (level[i]),
         .pulse_c (pulse_c[i])
      );
   end

   // OR the next-cycle pulses so any_q lands in the same cycle as q
   always_comb begin
      any_q_d = |pulse_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         any_q_q <= 1'b0;
      end else begin
         any_q_q <= any_q_d;
      end
   end

   assign any_q = any_q_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
module tb_edge_pulse_gen;

   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Default-parameter instance (4 channels, 2 sync, no filter, idle low)
   logic       rst0, en0;
   logic [3:0] d0, q0, lv0;
   logic [7:0] mode0;
   logic       any0;

   edge_pulse_gen u_dut0 (
      .clk(clk), .rst(rst0), .en(en0), .d(d0), .mode(mode0),
      .q(q0), .level(lv0), .any_q(any0)
   );

   // Filtered instance
   logic       rst1;
   logic [0:0] d1, q1, lv1;
   logic       any1;

   edge_pulse_gen #(.CHANNELS(1), .FILTER_CYCLES(4)) u_dut1 (
      .clk(clk), .rst(rst1), .en(1'b1), .d(d1), .mode(2'b11),
      .q(q1), .level(lv1), .any_q(any1)
   );

   // Idle-high instance, falling edges only
   logic       rst2;
   logic [0:0] d2, q2, lv2;
   logic       any2;

   edge_pulse_gen #(.CHANNELS(1), .INIT_LEVEL(1'b1)) u_dut2 (
      .clk(clk), .rst(rst2), .en(1'b1), .d(d2), .mode(2'b10),
      .q(q2), .level(lv2), .any_q(any2)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] d;
      logic [7:0] mode;
      logic [3:0] exp_q;
      logic [3:0] exp_lv;
      logic       exp_any;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic r, input logic e, input logic [3:0] d,
                      input logic [7:0] m, input logic [3:0] eq,
                      input logic [3:0] el, input logic ea);
      vec_t v;
      v.rst = r; v.en = e; v.d = d; v.mode = m;
      v.exp_q = eq; v.exp_lv = el; v.exp_any = ea;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      rst0 = 1'b1; en0 = 1'b1; d0 = 4'h0; mode0 = 8'hFF;
      rst1 = 1'b1; d1 = 1'b0;
      rst2 = 1'b1; d2 = 1'b1;

      // Reset and idle after release
      add(1,1,4'h0,8'hFF, 4'h0,4'h0,0);
      add(1,1,4'h0,8'hFF, 4'h0,4'h0,0);
      for (int k = 0; k < 6; k++) add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      // ch0 rise then fall, latency 3
      add(0,1,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h1,8'hFF, 4'h1,4'h1,1);
      add(0,1,4'h1,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h0,8'hFF, 4'h1,4'h0,1);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      // ch1 RISE, ch2 FALL, ch3 OFF
      add(0,1,4'hE,8'h27, 4'h0,4'h0,0);
      add(0,1,4'hE,8'h27, 4'h0,4'h0,0);
      add(0,1,4'hE,8'h27, 4'h2,4'hE,1);
      add(0,1,4'hE,8'h27, 4'h0,4'hE,0);
      add(0,1,4'h0,8'h27, 4'h0,4'hE,0);
      add(0,1,4'h0,8'h27, 4'h0,4'hE,0);
      add(0,1,4'h0,8'h27, 4'h4,4'h0,1);
      add(0,1,4'h0,8'h27, 4'h0,4'h0,0);
      // Mode changes alone
      add(0,1,4'h0,8'h00, 4'h0,4'h0,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h0,8'hAA, 4'h0,4'h0,0);
      // Simultaneous edges on all channels
      add(0,1,4'hF,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'hF,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'hF,8'hFF, 4'hF,4'hF,1);
      add(0,1,4'hF,8'hFF, 4'h0,4'hF,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'hF,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'hF,0);
      add(0,1,4'h0,8'hFF, 4'hF,4'h0,1);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      // ch0 toggling every cycle -> pulse every cycle
      add(0,1,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h1,8'hFF, 4'h1,4'h1,1);
      add(0,1,4'h0,8'hFF, 4'h1,4'h0,1);
      add(0,1,4'h0,8'hFF, 4'h1,4'h1,1);
      add(0,1,4'h0,8'hFF, 4'h1,4'h0,1);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      // Edge while disabled is lost; re-enable gives no stale pulse
      add(0,0,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,0,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,0,4'h1,8'hFF, 4'h0,4'h1,0);
      add(0,0,4'h1,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h1,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h1,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h1,0);
      add(0,1,4'h0,8'hFF, 4'h1,4'h0,1);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      // Reset mid-flight kills the pending edge
      add(0,1,4'h1,8'hFF, 4'h0,4'h0,0);
      add(1,1,4'h0,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h0,8'hFF, 4'h0,4'h0,0);
      // Input opposite to INIT_LEVEL at release -> one edge
      add(1,1,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h1,8'hFF, 4'h0,4'h0,0);
      add(0,1,4'h1,8'hFF, 4'h1,4'h1,1);
      add(0,1,4'h1,8'hFF, 4'h0,4'h1,0);

      // Immediate reset state before any clock edge
      #1;
      chk("reset_q", -1, q0, 4'h0);
      chk("reset_level", -1, lv0, 4'h0);
      chk("reset_any", -1, {3'b0, any0}, 4'h0);

      foreach (vecs[i]) begin
         rst0 = vecs[i].rst; en0 = vecs[i].en;
         d0 = vecs[i].d; mode0 = vecs[i].mode;
         @(posedge clk); #1;
         chk("q", i, q0, vecs[i].exp_q);
         chk("level", i, lv0, vecs[i].exp_lv);
         chk("any_q", i, {3'b0, any0}, {3'b0, vecs[i].exp_any});
      end

      // Async clear: reset asserted between edges clears state at once
      d0 = 4'h1; @(posedge clk); @(posedge clk); @(posedge clk); #1;
      chk("pre_async_level", 0, lv0, 4'h1);
      rst0 = 1'b1; #1;
      chk("async_level", 0, lv0, 4'h0);
      chk("async_q", 0, q0, 4'h0);
      d0 = 4'h0; @(posedge clk); #1; rst0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("async_after_q", k, q0, 4'h0);
      end

      // Filter of 4: 3-cycle glitch rejected
      rst1 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         d1 = (k <= 3) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         chk("glitch_q", k, {3'b0, q1}, 4'h0);
         chk("glitch_level", k, {3'b0, lv1}, 4'h0);
      end
      // 4-cycle pulse accepted at edge 6, its falling edge at edge 10
      for (int k = 1; k <= 12; k++) begin
         d1 = (k <= 4) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         chk("filt_q", k, {3'b0, q1}, (k == 6 || k == 10) ? 4'h1 : 4'h0);
         chk("filt_level", k, {3'b0, lv1}, (k >= 6 && k < 10) ? 4'h1 : 4'h0);
         chk("filt_any", k, {3'b0, any1}, (k == 6 || k == 10) ? 4'h1 : 4'h0);
      end

      // Idle-high line through reset, then a falling start bit
      chk("init_level", 0, {3'b0, lv2}, 4'h1);
      rst2 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         chk("idle_q", k, {3'b0, q2}, 4'h0);
         chk("idle_level", k, {3'b0, lv2}, 4'h1);
      end
      for (int k = 1; k <= 5; k++) begin
         d2 = 1'b0;
         @(posedge clk); #1;
         chk("rx_q", k, {3'b0, q2}, (k == 3) ? 4'h1 : 4'h0);
         chk("rx_level", k, {3'b0, lv2}, (k < 3) ? 4'h1 : 4'h0);
         chk("rx_any", k, {3'b0, any2}, (k == 3) ? 4'h1 : 4'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
Multi-channel, parametrised edge-to-pulse generator. It is the next-generation replacement for the single-bit change detector used in the UART and the rest of the computer. Each channel has:
- a metastability synchroniser,
- a programmable glitch/debounce filter,
- a per-channel runtime edge mode (off/rise/fall/both).

Each channel emits a registered one-clock pulse per qualifying edge. Typical consumers: UART RX start-bit detection, push-button inputs, and cross-domain strobes.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=1; 1 is allowed only for inputs already in the clk domain).
- FILTER_CYCLES, 1: consecutive cycles a new level must persist before it is accepted (>=1; 1 means no filtering).
- INIT_LEVEL, 1'b0: reset value of the synchroniser and filtered level. Use 1'b1 for idle-high lines such as UART RX.

Ports:
- clk, input, 1: system clock (50 MHz).
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: global pulse enable.
- d, input, CHANNELS: raw asynchronous inputs.
- mode, input, 2*CHANNELS: per-channel edge_mode_t; channel i uses bits [2i+1:2i].
- q, output, CHANNELS: one-clock edge pulses.
- level, output, CHANNELS: filtered, synchronised level per channel.
- any_q, output, 1: OR of q.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - sync chain and level = INIT_LEVEL per channel;
  - filter counters = 0;
  - q = 0, any_q = 0.
- Reset asserted mid-operation clears in-flight edges immediately. No pulse is generated on reset assertion or release.
- Synchroniser: d[i] passes through SYNC_STAGES flops, giving s[i].
- Filter, per channel, with counter cnt of width $clog2(FILTER_CYCLES+1):
  - if s == level: cnt <= 0;
  - else if cnt == FILTER_CYCLES-1: level <= s and cnt <= 0 (an accepted edge);
  - else: cnt <= cnt+1.
  - A glitch shorter than FILTER_CYCLES cycles at s resets the count and produces no edge.
- Edge qualification: rise = accepted edge with s=1; fall = accepted edge with s=0.
  - EDGE_OFF (2'b00): never pulses.
  - EDGE_RISE (2'b01): pulses on rise only.
  - EDGE_FALL (2'b10): pulses on fall only.
  - EDGE_BOTH (2'b11): pulses on either.
- Pulse timing:
  - q[i] is registered and asserts in the same cycle that level[i] changes, for exactly one cycle.
  - any_q is registered and equals OR(q) in the same cycle.
- Latency: edge 1 is the first rising clk edge that samples the new d. q goes high on edge SYNC_STAGES+FILTER_CYCLES and low on the following edge. With defaults, q is high after edge 3.
- en = 0 forces q and any_q to 0 on the next edge. The sync and filter keep tracking, so re-enabling never produces a stale pulse. An edge accepted while en=0 is lost.
- A mode change takes effect on the next accepted edge. A mode change by itself never produces a pulse.
- Back-to-back edges:
  - With FILTER_CYCLES=1, an input toggling every cycle produces a pulse every cycle in EDGE_BOTH.
  - Pulses on the same channel never merge or queue.
- Channels are fully independent. Simultaneous edges on several channels assert the corresponding q bits in the same cycle, with any_q=1.
- Inputs held at INIT_LEVEL through reset release produce no pulse. An input at the opposite level produces one accepted edge after the normal latency.

Decomposition:
- Package edge_pkg holds:
  - typedef enum logic [1:0] edge_mode_t {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH};
  - localparam DEF_SYNC_STAGES = 2.
- Sub-module edge_chan contains the synchroniser, filter counter, level register and mode-qualified pulse for a single bit. It takes parameters SYNC_STAGES, FILTER_CYCLES and INIT_LEVEL.
- edge_pulse_gen generates CHANNELS instances of edge_chan and registers any_q.

Test Plan:
1. Reset: rst=1, d=0, mode=all EDGE_BOTH → q=0, any_q=0, level=0 throughout. Release rst with d=0 held for 10 cycles → q stays 0.
2. Defaults, ch0 EDGE_BOTH, en=1: d[0] 0→1 mid-cycle → q[0]=1 exactly in the cycle after edge 3, then 0. d[0] 1→0 → the same one-cycle pulse. level[0] tracks with the same latency.
3. Mode filtering, ch1=EDGE_RISE, ch2=EDGE_FALL, ch3=EDGE_OFF: toggle d[3:1] 000→111→000 → q[1] pulses on rise only, q[2] on fall only, q[3] never. Simultaneous edges give q bits in the same cycle and any_q=1.
4. Filter, FILTER_CYCLES=4: a 3-cycle-wide high glitch on d[0] → no pulse, level stays 0. A 4-cycle-wide high → one pulse, asserted on edge 2+4=6 after the first sample.
5. Enable and reset mid-flight: en=0 while d[0] rises → no pulse; en=1 later → no pulse. Assert rst 1 cycle after d[0] rises (before q) → q never asserts, level=INIT_LEVEL.
6. INIT_LEVEL=1, ch0=EDGE_FALL (UART-RX style): d idle 1 through reset → no pulse. d falls to 0 → single q[0] pulse at latency 3.
